// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debug run/halt/step/core-reset controller for the core clock.
// Ports: sysclk, sys_reset (sync, active-high); cmd_valid/cmd/step_count in;
//   pc/bp_addr/bp_en breakpoint inputs; cmd_ready, core_clk_en, dm_reset,
//   halted, step_done, bp_hit out. Optional breakpoint: DBG_BREAKPOINT_EN.
module dbg_run_ctrl #(
   parameter int RESET_CYCLES = 4,
   parameter int STEP_W       = 8
) (
   input  logic              sysclk,
   input  logic              sys_reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd,
   input  logic [STEP_W-1:0] step_count,
   input  logic [31:0]       pc,
   input  logic [31:0]       bp_addr,
   input  logic              bp_en,
   output logic              cmd_ready,
   output logic              core_clk_en,
   output logic              dm_reset,
   output logic              halted,
   output logic              step_done,
   output logic              bp_hit
);

   typedef enum logic [1:0] {
      S_RUN  = 2'b00,
      S_HALT = 2'b01,
      S_STEP = 2'b10,
      S_CRST = 2'b11
   } state_t;

   localparam logic [1:0] CMD_RUN  = 2'b00;
   localparam logic [1:0] CMD_HALT = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;
   localparam logic [1:0] CMD_CRST = 2'b11;

   state_t            state;
   state_t            nxt;
   logic [STEP_W-1:0] step_cnt;
   logic [7:0]        rst_cnt;
   logic              clk_en_q;
   logic              accept;
   logic              bp_stop;
   logic              zero_step;

   assign cmd_ready = (state == S_RUN) || (state == S_HALT);
   assign accept    = cmd_valid && cmd_ready;
   assign zero_step = accept && (cmd == CMD_STEP) && (step_count == '0);

`ifdef DBG_BREAKPOINT_EN
   // A match only stops a free-running core; a same-cycle command wins
   // and reset overrides everything.
   assign bp_stop = (state == S_RUN) && bp_en && (pc == bp_addr)
                    && !cmd_valid && !sys_reset;
   logic bp_hit_q;
   assign bp_hit = bp_hit_q;
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr, bp_en};
   assign bp_stop   = 1'b0;
   assign bp_hit    = 1'b0;
`endif

   // Breakpoint gating must act in the matching cycle, so it bypasses
   // the registered enable.
   assign core_clk_en = clk_en_q && !bp_stop;

   always_comb begin
      nxt = state;
      unique case (state)
         S_RUN, S_HALT: begin
            if (accept) begin
               unique case (cmd)
                  CMD_RUN:  nxt = S_RUN;
                  CMD_HALT: nxt = S_HALT;
                  CMD_STEP: nxt = zero_step ? S_HALT : S_STEP;
                  CMD_CRST: nxt = S_CRST;
               endcase
            end else if (bp_stop) begin
               nxt = S_HALT;
            end
         end
         S_STEP: if (step_cnt <= STEP_W'(1)) nxt = S_HALT;
         S_CRST: if (rst_cnt <= 8'd1) nxt = S_HALT;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (sys_reset) begin
         state     <= S_RUN;
         clk_en_q  <= 1'b1;
         dm_reset  <= 1'b0;
         halted    <= 1'b0;
         step_done <= 1'b0;
         step_cnt  <= '0;
         rst_cnt   <= '0;
`ifdef DBG_BREAKPOINT_EN
         bp_hit_q  <= 1'b0;
`endif
      end else begin
         state     <= nxt;
         clk_en_q  <= (nxt != S_HALT);
         dm_reset  <= (nxt == S_CRST);
         halted    <= (nxt == S_HALT);
         step_done <= (nxt == S_HALT) && ((state == S_STEP) || zero_step);
`ifdef DBG_BREAKPOINT_EN
         bp_hit_q  <= bp_stop;
`endif
         // Counters saturate at zero; each entry reloads them.
         if (accept && (cmd == CMD_STEP))
            step_cnt <= step_count;
         else if ((state == S_STEP) && (step_cnt != '0))
            step_cnt <= step_cnt - STEP_W'(1);

         if (accept && (cmd == CMD_CRST))
            rst_cnt <= 8'(RESET_CYCLES);
         else if ((state == S_CRST) && (rst_cnt != 8'd0))
            rst_cnt <= rst_cnt - 8'd1;
      end
   end

endmodule
